bnn_mv_engine: RTL
==================

Name: bnn_mv_engine

Overview:
Parametrised XNOR-popcount matrix-vector engine for the binary neural network (BNN) accelerator, and successor to the fixed 64x64 array under accelerator_top. It runs NUM_PES PEs in parallel, one per output row, over a runtime-selectable vector length. Each PE owns a private weight SRAM; one shared activation SRAM feeds all PEs. Outputs are match counts, bipolar dot products or thresholded binary activations, the last feeding the next BNN layer directly.

Parameters:
WORD_SIZE, 64, bits per SRAM word and per XNOR step
NUM_PES, 64, number of parallel PEs (output rows)
SRAM_DEPTH, 64, words per weight row and in the activation vector
ACC_W, 16, accumulator/result width; elaboration error if ACC_W < $clog2(WORD_SIZE*SRAM_DEPTH+1)+1

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  single-cycle request; honoured only in IDLE
cfg_len  in  $clog2(SRAM_DEPTH+1)  number of words to process; valid range 1..SRAM_DEPTH
cfg_mode  in  2  0=match count, 1=bipolar signed dot, 2=binarize vs threshold, 3=reserved (rejected)
busy  out  1  high while a job runs
done  out  1  one-cycle pulse when results are valid
err  out  1  one-cycle pulse on a rejected start or a rejected write
wr_en  in  1  write strobe
wr_type  in  2  0=weight, 1=activation, 2=threshold, 3=reserved (rejected)
wr_pe_idx  in  $clog2(NUM_PES)  target PE for weight/threshold writes
wr_addr  in  $clog2(SRAM_DEPTH)  word address; ignored for threshold writes
wr_data  in  WORD_SIZE  write data; threshold uses the low ACC_W bits
results_out  out  NUM_PES*ACC_W  PE p in bits [p*ACC_W +: ACC_W]; valid from done until the next accepted start
bin_out  out  NUM_PES  mode-2 binary outputs, bit p = PE p; zero in other modes

Behaviour:
- Reset (reset_n=0 at an edge): FSM to IDLE. busy, done, err, results_out, bin_out and all accumulators cleared. SRAM contents and thresholds are not reset. A reset mid-job aborts it and no done is issued.
- FSM states IDLE -> FILL -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start with cfg_len in 1..SRAM_DEPTH and cfg_mode != 3: latch len and mode, clear accumulators, go to FILL.
  - Otherwise an err pulse the next cycle; the FSM stays in IDLE.
- FILL: issue read address 0 to all SRAMs (synchronous read, 1-cycle latency).
- RUN: issue addresses 1..len-1 on consecutive cycles. Each PE computes matches = WORD_SIZE - popcount(w XOR a) on the returned data and registers it (1 stage). It then adds the value into its accumulator the following cycle.
- DRAIN: flush the pipeline.
- DONE: write the output register and pulse done for one cycle, then return to IDLE.
- Latency: start sampled at edge T. done is high during the cycle after edge T+len+3. busy is high from T+1 through the done cycle inclusive.
- Output formats, with N = len*WORD_SIZE:
  - mode 0: results = matches, unsigned.
  - mode 1: results = 2*matches - N, two's complement in ACC_W.
  - mode 2: bin_out[p] = (matches >= threshold[p]) and results = matches.
- Writes:
  - Accepted in IDLE and DONE; memory write lands at the edge.
  - wr_en while busy (FILL/RUN/DRAIN) or with wr_type=3: write dropped, err pulse.
  - Writes never corrupt an in-flight job.
- start while busy is ignored with no err pulse. start coinciding with wr_en in IDLE: the write completes and the job starts; the job reads the new data only if the address is read at least one cycle later.
- Boundaries:
  - len=1 gives done at T+4.
  - len=SRAM_DEPTH reads the last address SRAM_DEPTH-1 with no wrap.
  - The maximum accumulator value is WORD_SIZE*SRAM_DEPTH and must not overflow.

Decomposition:
- Package bnn_pkg:
  - mode and write-type enums (MODE_COUNT, MODE_BIPOLAR, MODE_BINARIZE; WR_WEIGHT, WR_ACT, WR_THRESH)
  - FSM state enum
  - popcount function
  - ACC_W minimum-width check constant
- Sub-module bnn_pe: weight SRAM, threshold register, XNOR/popcount stage, accumulator and output formatting. The top holds the FSM, address counter, activation SRAM and write decode, and generates NUM_PES bnn_pe instances.

Test Plan:
- Identity weights (PE p, word p = all 1s, others 0), activations alternating AAAA.../5555..., len=64, mode 0 -> every results = 2048, done exactly 67 cycles after start.
- Same data, mode 1 -> every results = 0. All weights 1s, all activations 1s, len=4, mode 1 -> every results = 256.
- All-ones data, len=4, mode 2, threshold[p] = p*8 -> bin_out[p] = 1 for p <= 32, 0 for p >= 33; results = 256.
- start with cfg_len=0, then cfg_len=65, then cfg_mode=3 -> err pulse each time, busy stays 0, no done.
- wr_en during RUN targeting PE 0 word 0 -> err pulse, write dropped, result unchanged versus the golden value. start during RUN -> ignored.
- reset_n low for 1 cycle mid-RUN -> outputs zero, no done. A new start then completes with correct values (SRAMs retained).

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the XNOR-popcount matrix-vector engine:
// job modes, write types, FSM states, popcount and accumulator width bound.
package bnn_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT    = 2'd0,
    MODE_BIPOLAR  = 2'd1,
    MODE_BINARIZE = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    WR_WEIGHT = 2'd0,
    WR_ACT    = 2'd1,
    WR_THRESH = 2'd2,
    WR_RSVD   = 2'd3
  } wr_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Widest word popcount() accepts; narrower words are zero-extended.
  localparam int POP_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < POP_MAX_W; i++) cnt += 32'(v[i]);
    return cnt;
  endfunction

  // Accumulator must hold WORD_SIZE*SRAM_DEPTH plus a sign bit for bipolar results.
  function automatic int acc_w_min(input int word_size, input int depth);
    return $clog2(word_size * depth + 1) + 1;
  endfunction

endpackage

// File: rtl/bnn_pe.sv
// One output row: private weight SRAM, threshold register, XNOR/popcount
// stage, match accumulator and mode-dependent output register.
module bnn_pe
  import bnn_pkg::*;
#(
  parameter int WORD_SIZE  = 64,
  parameter int SRAM_DEPTH = 64,
  parameter int ACC_W      = 16,
  parameter int AW         = $clog2(SRAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 w_we,
  input  logic                 th_we,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  input  logic [WORD_SIZE-1:0] act_p1,
  input  logic                 vld_p2,
  input  logic                 acc_clr,
  input  logic                 out_load,
  input  mode_e                mode,
  input  logic [ACC_W-1:0]     n_bits,
  output logic [ACC_W-1:0]     result,
  output logic                 bin
);

  logic [WORD_SIZE-1:0] mem [SRAM_DEPTH];
  logic [WORD_SIZE-1:0] w_p1_q;
  logic [ACC_W-1:0]     thresh_q;
  logic [ACC_W-1:0]     match_p2_q, match_p2_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     result_q, result_d;
  logic                 bin_q, bin_d;

  // Stage p1: weight word read alongside the shared activation word
  always_ff @(posedge clk) begin
    if (w_we)  mem[wr_addr] <= wr_data;
    if (rd_en) w_p1_q <= mem[rd_addr];
    if (th_we) thresh_q <= wr_data[ACC_W-1:0];
    match_p2_q <= match_p2_d;
  end

  always_comb begin
    match_p2_d = ACC_W'(WORD_SIZE - popcount(POP_MAX_W'(w_p1_q ^ act_p1)));
    acc_d      = acc_q;
    if (acc_clr)     acc_d = '0;
    else if (vld_p2) acc_d = acc_q + match_p2_q;
    result_d = result_q;
    bin_d    = bin_q;
    if (out_load) begin
      case (mode)
        MODE_BIPOLAR: result_d = (acc_q << 1) - n_bits;
        default:      result_d = acc_q;
      endcase
      bin_d = (mode == MODE_BINARIZE) && (acc_q >= thresh_q);
    end
  end

  // Stage p2 -> p3: accumulate and format
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q    <= '0;
      result_q <= '0;
      bin_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
      bin_q    <= bin_d;
    end
  end

  assign result = result_q;
  assign bin    = bin_q;

endmodule

// File: rtl/bnn_mv_engine.sv
// XNOR-popcount matrix-vector engine: job FSM, read address sequencing,
// shared activation SRAM, write decode and NUM_PES parallel row PEs.
module bnn_mv_engine
  import bnn_pkg::*;
#(
  parameter int WORD_SIZE  = 64,
  parameter int NUM_PES    = 64,
  parameter int SRAM_DEPTH = 64,
  parameter int ACC_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [$clog2(SRAM_DEPTH+1)-1:0] cfg_len,
  input  logic [1:0]                    cfg_mode,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_type,
  input  logic [$clog2(NUM_PES)-1:0]    wr_pe_idx,
  input  logic [$clog2(SRAM_DEPTH)-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]          wr_data,
  output logic [NUM_PES*ACC_W-1:0]      results_out,
  output logic [NUM_PES-1:0]            bin_out
);

  localparam int LEN_W = $clog2(SRAM_DEPTH + 1);
  localparam int AW    = $clog2(SRAM_DEPTH);
  localparam int PE_W  = $clog2(NUM_PES);

  if (ACC_W < acc_w_min(WORD_SIZE, SRAM_DEPTH)) begin : g_acc_w_chk
    $error("bnn_mv_engine: ACC_W too narrow for WORD_SIZE*SRAM_DEPTH");
  end

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 drain_q, drain_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 vld_p1_q, vld_p1_d, vld_p2_q;
  logic                 rd_en, acc_clr, out_load, wr_ok;
  logic [AW-1:0]        rd_addr;
  logic [WORD_SIZE-1:0] act_mem [SRAM_DEPTH];
  logic [WORD_SIZE-1:0] act_p1_q;
  logic [ACC_W-1:0]     n_bits;
  wr_type_e             wr_kind;

  assign wr_kind = wr_type_e'(wr_type);
  assign n_bits  = ACC_W'(len_q * WORD_SIZE);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    addr_d   = addr_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    acc_clr  = 1'b0;
    out_load = 1'b0;
    // Writes only in IDLE/DONE so an in-flight job never sees a changing SRAM.
    wr_ok = wr_en && (wr_kind != WR_RSVD) && (state_q == ST_IDLE || state_q == ST_DONE);
    if (wr_en && !wr_ok) err_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len != '0 && cfg_len <= LEN_W'(SRAM_DEPTH) && mode_e'(cfg_mode) != MODE_RSVD) begin
            len_d   = cfg_len;
            mode_d  = mode_e'(cfg_mode);
            acc_clr = 1'b1;
            state_d = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        rd_en   = 1'b1;
        addr_d  = AW'(1);
        drain_d = 1'b0;
        state_d = (len_q == LEN_W'(1)) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
        addr_d  = addr_q + AW'(1);
        if (addr_q == AW'(len_q - LEN_W'(1))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Two cycles: one for the match register, one for the last accumulate.
        drain_d = 1'b1;
        if (drain_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_load = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    vld_p1_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_COUNT;
      len_q    <= '0;
      addr_q   <= '0;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      err_q    <= err_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Stage p1: shared activation word, read in step with every weight SRAM
  always_ff @(posedge clk) begin
    if (wr_ok && wr_kind == WR_ACT) act_mem[wr_addr] <= wr_data;
    if (rd_en) act_p1_q <= act_mem[rd_addr];
  end

  for (genvar p = 0; p < NUM_PES; p++) begin : g_pe
    bnn_pe #(
      .WORD_SIZE (WORD_SIZE),
      .SRAM_DEPTH(SRAM_DEPTH),
      .ACC_W     (ACC_W),
      .AW        (AW)
    ) u_pe (
      .clk     (clk),
      .reset_n (reset_n),
      .w_we    (wr_ok && wr_kind == WR_WEIGHT && wr_pe_idx == PE_W'(p)),
      .th_we   (wr_ok && wr_kind == WR_THRESH && wr_pe_idx == PE_W'(p)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .act_p1  (act_p1_q),
      .vld_p2  (vld_p2_q),
      .acc_clr (acc_clr),
      .out_load(out_load),
      .mode    (mode_q),
      .n_bits  (n_bits),
      .result  (results_out[p*ACC_W +: ACC_W]),
      .bin     (bin_out[p])
    );
  end

  assign busy = (state_q != ST_IDLE) || done_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
